led_breathe: RTL and testbench
==============================

# led_breathe

Downstream consumer of the LED blink-rate counter stage. It takes that stage's one-cycle rate tick and produces a "breathing" LED: PWM duty ramps 0 → max → 0 continuously. The PWM output drives the board LED pin directly. It also exposes the current duty level and a per-breath completion pulse for debug and status.

## Interface
- `PWM_BITS`, default 8: width of the duty and PWM counter; full scale is `MAX = 2**PWM_BITS-1`.
- `STEP_DIV`, default 4: number of `tick_i` pulses per duty step. Must be ≥ 1.
- `PEAK_STEPS`, default 16: steps held at `MAX`. Used only when the macro under Configuration is defined.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tick_i` input 1: one-cycle rate pulse from the upstream counter stage.
- `en_i` input 1: level enable. Low forces idle/off.
- `led_o` output 1: registered PWM output. Reset 0.
- `duty_o` output PWM_BITS: working duty register. Reset 0.
- `rising_o` output 1: 1 while in RISE, or in PEAK when hold is enabled. Reset 0.
- `cycle_done_o` output 1: one-cycle pulse when a full breath completes. Reset 0.

## Operation
- The FSM has states IDLE, RISE, PEAK and FALL. PEAK exists only with the macro. Reset state is IDLE.
- IDLE
  - `duty_o`=0, step counter=0.
  - `en_i`=1 → RISE on the next edge.
  - `tick_i` is ignored in the cycle IDLE is left.
- Step counter
  - Counts `tick_i` pulses in RISE, PEAK and FALL.
  - On the `STEP_DIV`-th tick it wraps to 0 and issues a step.
- RISE: each step increments `duty_o`. The step that makes `duty_o`=MAX moves to PEAK if the macro is defined, otherwise to FALL.
- PEAK: counts steps. After `PEAK_STEPS` steps it moves to FALL. `duty_o` stays at MAX.
- FALL
  - Each step decrements `duty_o`.
  - The step that makes `duty_o`=0 moves to RISE and asserts `cycle_done_o` in the same cycle as `duty_o` becomes 0.
- `en_i`=0 in any state → IDLE on the next edge. In that same edge `duty_o`=0, the step counter is cleared and PEAK progress is cleared. Re-enable always starts from duty 0 with a fresh step count.
- PWM
  - `pwm_cnt` runs freely 0..MAX and wraps; it is active in all states.
  - `duty_act` is a shadow copy of `duty_o`, loaded only in the cycle where `pwm_cnt`==MAX. This makes duty changes glitch-free, aligned to PWM period boundaries.
  - Exception: leaving for IDLE clears `duty_act` immediately.
- Next-state value of `led_o` = `en_i` && state≠IDLE && (`pwm_cnt` < `duty_act`). Duty 0 gives always off; duty MAX gives on for MAX of every MAX+1 cycles.
- Arithmetic: duty never wraps. Increment saturates at MAX and decrement stops at 0; FSM transitions guarantee this.
- Steps per breath: 2·MAX without hold, 2·MAX+`PEAK_STEPS` with hold.

## Timing
- `tick_i` sampled in cycle t → `duty_o` updated at edge t+1. `cycle_done_o` is high only in cycle t+1, i.e. for one cycle.
- `duty_o` change → takes effect on `led_o` at the next `pwm_cnt` wrap plus 1 cycle, because `led_o` is registered.
- `en_i` falls at t → `led_o`=0, `duty_o`=0 and `rising_o`=0 from t+1.
- If `tick_i` coincides with `en_i` falling, the tick is discarded.
- `rst` asserted mid-operation → all outputs and state are forced to reset values immediately, asynchronously. Release resumes in IDLE.

## Configuration
- Macro: `LED_BREATHE_PEAK_HOLD_EN`.
- Defined: the PEAK state exists. Duty dwells at MAX for `PEAK_STEPS` steps between RISE and FALL, and `rising_o` stays 1 through PEAK.
- Undefined: there is no PEAK state and no PEAK counter. RISE goes directly to FALL, and `PEAK_STEPS` is ignored.

## Test plan
All scenarios use `PWM_BITS`=4 (MAX=15) and `STEP_DIV`=2 unless noted.
- **Reset:** hold `rst`=1 with `en_i`=1 and `tick_i` toggling → `led_o`=0, `duty_o`=0, `rising_o`=0, `cycle_done_o`=0 throughout. After release, first step happens after 2 ticks → `duty_o`=1.
- **Full breath, macro undefined:** `en_i`=1, `tick_i`=1 every cycle → `duty_o`=15 after 30 ticks and `rising_o` falls. `duty_o`=0 after 60 ticks with exactly one `cycle_done_o` pulse, then rises again.
- **PWM accuracy:** freeze the ramp at `duty_o`=5 by holding `tick_i`=0 → `led_o` high exactly 5 of every 16 cycles. A step to 6 issued mid-period is first seen in the following period.
- **Disable mid-rise:** drop `en_i` at `duty_o`=7 → next cycle `duty_o`=0 and `led_o`=0. Re-enable with a tick in the first cycle → that tick is ignored, and `duty_o`=1 only after 2 further ticks.
- **Peak hold:** macro defined, `PEAK_STEPS`=3 → `duty_o` holds 15 for 6 ticks, and `cycle_done_o` pulses at tick 66.
- **Async reset mid-FALL:** assert `rst` between edges at `duty_o`=9 → outputs clear without waiting for a clock edge. After release the block restarts from IDLE.

Source files
------------

// File: rtl/led_breathe.sv
// Breathing-LED generator: ramps a PWM duty 0 -> MAX -> 0, one step per STEP_DIV rate ticks.
// Optional dwell at full brightness is built when LED_BREATHE_PEAK_HOLD_EN is defined.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 4,
  parameter int PEAK_STEPS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                en_i,
  output logic                led_o,
  output logic [PWM_BITS-1:0] duty_o,
  output logic                rising_o,
  output logic                cycle_done_o
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX_V = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ONE_V = PWM_BITS'(1);

  if (STEP_DIV < 1 || PEAK_STEPS < 1) begin : g_bad_params
    $error("led_breathe: STEP_DIV and PEAK_STEPS must be >= 1");
  end

`ifdef LED_BREATHE_PEAK_HOLD_EN
  localparam int PW = (PEAK_STEPS > 1) ? $clog2(PEAK_STEPS) : 1;
  localparam logic [PW-1:0] PEAK_LAST = PW'(PEAK_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_PEAK = 2'd2,
    S_FALL = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd3
  } state_e;
`endif

  state_e                state_q, state_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [SW-1:0]         step_q, step_d;
  logic                  done_q, done_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [PWM_BITS-1:0]   dact_q, dact_d;
  logic                  led_q, led_d;
  logic                  step_hit;
`ifdef LED_BREATHE_PEAK_HOLD_EN
  logic [PW-1:0]         peak_q, peak_d;
`endif

  assign step_hit = tick_i && (step_q == STEP_LAST);

  // Breath FSM; ticks are only counted once the ramp is running, never in IDLE.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    step_d  = step_q;
    done_d  = 1'b0;
`ifdef LED_BREATHE_PEAK_HOLD_EN
    peak_d  = peak_q;
`endif
    if (!en_i) begin
      state_d = S_IDLE;
      duty_d  = '0;
      step_d  = '0;
`ifdef LED_BREATHE_PEAK_HOLD_EN
      peak_d  = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_RISE;
          duty_d  = '0;
          step_d  = '0;
        end
        default: begin
          if (tick_i) begin
            step_d = step_hit ? '0 : step_q + SW'(1);
          end
          if (step_hit) begin
            case (state_q)
              S_RISE: begin
                if (duty_q != MAX_V) begin
                  duty_d = duty_q + ONE_V;
                end
                if (duty_q == MAX_V - ONE_V) begin
`ifdef LED_BREATHE_PEAK_HOLD_EN
                  state_d = S_PEAK;
`else
                  state_d = S_FALL;
`endif
                end
              end
`ifdef LED_BREATHE_PEAK_HOLD_EN
              S_PEAK: begin
                if (peak_q == PEAK_LAST) begin
                  peak_d  = '0;
                  state_d = S_FALL;
                end else begin
                  peak_d = peak_q + PW'(1);
                end
              end
`endif
              S_FALL: begin
                if (duty_q != '0) begin
                  duty_d = duty_q - ONE_V;
                end
                if (duty_q == ONE_V) begin
                  state_d = S_RISE;
                  done_d  = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // PWM: duty is shadowed at the period boundary so the pulse width never changes mid-period.
  always_comb begin
    pwm_d  = pwm_q + ONE_V;
    dact_d = dact_q;
    if (!en_i) begin
      dact_d = '0;
    end else if (pwm_q == MAX_V) begin
      dact_d = duty_q;
    end
    led_d = en_i && (state_q != S_IDLE) && (pwm_q < dact_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      pwm_q   <= '0;
      dact_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      step_q  <= step_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
      dact_q  <= dact_d;
      led_q   <= led_d;
    end
  end

`ifdef LED_BREATHE_PEAK_HOLD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign rising_o = (state_q == S_RISE) || (state_q == S_PEAK);
`else
  assign rising_o = (state_q == S_RISE);
`endif

  assign led_o        = led_q;
  assign duty_o       = duty_q;
  assign cycle_done_o = done_q;

endmodule

// File: tb/tb_led_breathe.sv
// Bench for led_breathe: directed breath/PWM/disable/reset scenarios plus random traffic,
// all checked against a step-count model of the breath profile.
module tb_led_breathe;

  localparam int PWM_BITS   = 4;
  localparam int STEP_DIV   = 2;
  localparam int PEAK_STEPS = 3;
  localparam int MAX        = 15;
`ifdef LED_BREATHE_PEAK_HOLD_EN
  localparam int PH = PEAK_STEPS;
`else
  localparam int PH = 0;
`endif
  localparam int BREATH = 2 * MAX + PH;

  logic                clk = 1'b0;
  logic                rst;
  logic                tick_i;
  logic                en_i;
  logic                led_o;
  logic [PWM_BITS-1:0] duty_o;
  logic                rising_o;
  logic                cycle_done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  led_breathe #(
    .PWM_BITS  (PWM_BITS),
    .STEP_DIV  (STEP_DIV),
    .PEAK_STEPS(PEAK_STEPS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_i      (tick_i),
    .en_i        (en_i),
    .led_o       (led_o),
    .duty_o      (duty_o),
    .rising_o    (rising_o),
    .cycle_done_o(cycle_done_o)
  );

  // Reference model: breath position is just the number of completed steps since enable.
  bit m_active;
  int m_ticks;
  int m_k;
  int m_pwm;
  int m_dact;
  bit m_led;
  bit m_done;

  function automatic int duty_of(input int k);
    int p;
    p = k % BREATH;
    if (p <= MAX) return p;
    if (p <= MAX + PH) return MAX;
    return BREATH - p;
  endfunction

  function automatic int m_duty();
    return m_active ? duty_of(m_k) : 0;
  endfunction

  function automatic bit m_rising();
    return m_active && ((m_k % BREATH) < MAX + PH);
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_ticks  = 0;
    m_k      = 0;
    m_pwm    = 0;
    m_dact   = 0;
    m_led    = 1'b0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit tick);
    int duty_pre;
    duty_pre = m_duty();
    m_led    = en && m_active && (m_pwm < m_dact);
    if (!en) m_dact = 0;
    else if (m_pwm == MAX) m_dact = duty_pre;
    m_pwm  = (m_pwm + 1) % (MAX + 1);
    m_done = 1'b0;
    if (!en) begin
      m_active = 1'b0;
      m_ticks  = 0;
      m_k      = 0;
    end else if (!m_active) begin
      m_active = 1'b1;
    end else if (tick) begin
      m_ticks++;
      if (m_ticks == STEP_DIV) begin
        m_ticks = 0;
        m_k++;
        m_done = ((m_k % BREATH) == 0);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".duty"},   32'(duty_o),       32'(m_duty()));
    check({ph, ".led"},    32'(led_o),        32'(m_led));
    check({ph, ".rising"}, 32'(rising_o),     32'(m_rising()));
    check({ph, ".done"},   32'(cycle_done_o), 32'(m_done));
  endtask

  task automatic check_zero(input string ph);
    check({ph, ".duty0"},   32'(duty_o),       32'd0);
    check({ph, ".led0"},    32'(led_o),        32'd0);
    check({ph, ".rising0"}, 32'(rising_o),     32'd0);
    check({ph, ".done0"},   32'(cycle_done_o), 32'd0);
  endtask

  task automatic step(input string ph, input bit en, input bit tick);
    en_i   = en;
    tick_i = tick;
    @(posedge clk);
    model_edge(en, tick);
    #1;
    check_all(ph);
  endtask

  initial begin
    int pulses;
    int cnt;
    bit found;

    rst    = 1'b1;
    en_i   = 1'b1;
    tick_i = 1'b0;
    model_reset();

    // Reset held with live inputs
    for (int i = 0; i < 8; i++) begin
      tick_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    rst = 1'b0;

    // One full breath with a tick every cycle
    pulses = 0;
    step("breath", 1'b1, 1'b1);
    for (int i = 0; i < 2 * BREATH; i++) begin
      step("breath", 1'b1, 1'b1);
      pulses += int'(cycle_done_o);
      if (i == 1) check("first_step", 32'(duty_o), 32'd1);
      if (i == 2 * MAX - 1) check("at_max", 32'(duty_o), 32'(MAX));
    end
    check("breath_pulses", 32'(pulses), 32'd1);
    check("breath_end", 32'(duty_o), 32'd0);
    step("rerise", 1'b1, 1'b1);
    step("rerise", 1'b1, 1'b1);

    // Disable mid-rise at duty 7
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_duty() == 7 && m_rising()) found = 1'b1;
      else step("to7", 1'b1, 1'b1);
    end
    check("reach7", 32'(found), 32'd1);
    step("dis", 1'b0, 1'b0);
    check("dis.duty_now", 32'(duty_o), 32'd0);
    check("dis.led_now", 32'(led_o), 32'd0);
    step("reen", 1'b1, 1'b1);
    step("reen", 1'b1, 1'b1);
    check("reen.one_tick", 32'(duty_o), 32'd0);
    step("reen", 1'b1, 1'b1);
    check("reen.two_ticks", 32'(duty_o), 32'd1);

    // Frozen ramp at duty 5, then a mid-period step to 6
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_duty() == 5 && m_rising() && m_ticks == 0) found = 1'b1;
      else step("to5", 1'b1, 1'b1);
    end
    check("reach5", 32'(found), 32'd1);
    for (int i = 0; i < 20; i++) step("hold5", 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step("pwm5", 1'b1, 1'b0);
      cnt += int'(led_o);
    end
    check("pwm5.count", 32'(cnt), 32'd5);
    while (m_pwm != 8) step("mid", 1'b1, 1'b0);
    step("mid", 1'b1, 1'b1);
    step("mid", 1'b1, 1'b1);
    check("mid.duty6", 32'(duty_o), 32'd6);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step("mid_same", 1'b1, 1'b0);
      if (m_pwm == 0) break;
      cnt += int'(led_o);
    end
    for (int i = 0; i < 18; i++) step("hold6", 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step("pwm6", 1'b1, 1'b0);
      cnt += int'(led_o);
    end
    check("pwm6.count", 32'(cnt), 32'd6);

    // Asynchronous reset while falling through duty 9
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (m_duty() == 9 && m_active && !m_rising()) found = 1'b1;
      else step("to9", 1'b1, 1'b1);
    end
    check("reach9", 32'(found), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold2");
    end
    rst = 1'b0;
    step("restart", 1'b1, 1'b0);
    check("restart.rising", 32'(rising_o), 32'd1);
    step("restart", 1'b1, 1'b1);
    step("restart", 1'b1, 1'b1);
    check("restart.duty1", 32'(duty_o), 32'd1);

    // Random traffic with occasional disables
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
